// File: rtl/lift_door_ctrl.sv
// ---------------------------------------------------------------------------
// lift_door_ctrl
//
// Door controller for the lift car. Sequences door opening, dwell, closing
// and obstruction reversal, drives the door motor enables, and gives the
// motion controller a door-closed interlock. Motion with the door not closed
// raises a sticky fault.
//
// Optional build macro: LIFT_DOOR_NUDGE_EN
//   Defined   : after NUDGE_LIMIT reversals in one stop the door enters nudge
//               mode (nudge=1); obstruct then neither reverses a closing door
//               nor restarts the open dwell. open_btn still reopens.
//   Undefined : no reversal counter, nudge is tied 0.
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   arrive       in   one-cycle pulse, car stopped at a floor
//   open_btn     in   door-open button, level
//   close_btn    in   door-close button, one-cycle pulse
//   obstruct     in   light-curtain obstruction, 1 = blocked
//   car_moving   in   car motion level from the motion controller
//   door_open    out  1 whenever the door is not fully closed
//   door_closed  out  1 only in CLOSED (motion interlock)
//   motor_open   out  opening motor enable
//   motor_close  out  closing motor enable
//   music_en     out  in-car music enable
//   fault        out  sticky safety fault
//   nudge        out  nudge-mode indicator
//
// States
//   state       | meaning
//   ST_CLOSED   | door shut, interlock asserted, waiting for a request
//   ST_OPENING  | opening motor on for MOVE_CYCLES (or the reversal remainder)
//   ST_OPEN     | door fully open, dwell timer running
//   ST_CLOSING  | closing motor on, open_btn/obstruct reverse the door
// ---------------------------------------------------------------------------
module lift_door_ctrl #(
    parameter int MOVE_CYCLES = 100000000,
    parameter int HOLD_CYCLES = 300000000,
    parameter int CNT_W       = 32,
    parameter int NUDGE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arrive,
    input  logic open_btn,
    input  logic close_btn,
    input  logic obstruct,
    input  logic car_moving,
    output logic door_open,
    output logic door_closed,
    output logic motor_open,
    output logic motor_close,
    output logic music_en,
    output logic fault,
    output logic nudge
);

    // Elaboration-time parameter sanity checks.
    if (MOVE_CYCLES < 2) begin : g_bad_move
        $error("lift_door_ctrl: MOVE_CYCLES must be at least 2");
    end
    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("lift_door_ctrl: HOLD_CYCLES must be at least 2");
    end
    if ((((MOVE_CYCLES - 1) >> CNT_W) != 0) || (((HOLD_CYCLES - 1) >> CNT_W) != 0)) begin : g_bad_cnt_w
        $error("lift_door_ctrl: CNT_W too narrow for MOVE_CYCLES/HOLD_CYCLES");
    end
    if (NUDGE_LIMIT < 1) begin : g_bad_nudge
        $error("lift_door_ctrl: NUDGE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    logic door_open_q, door_closed_q, motor_open_q, motor_close_q;
    logic music_en_q, fault_q;

    logic rev_inc;      // a reversal happens this cycle
    logic rev_clr;      // door reaches CLOSED this cycle
    logic nudge_act;    // obstruct is being ignored
    logic hold_req;     // request that holds OPEN or reverses CLOSING

`ifdef LIFT_DOOR_NUDGE_EN
    localparam int               REV_W   = $clog2(NUDGE_LIMIT + 1);
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(NUDGE_LIMIT);

    logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
    logic             nudge_q;

    always_comb begin
        rev_cnt_d = rev_cnt_q;
        if (rev_clr) begin
            rev_cnt_d = '0;
        end else if (rev_inc && (rev_cnt_q < REV_MAX)) begin
            rev_cnt_d = rev_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rev_cnt_q <= '0;
            nudge_q   <= 1'b0;
        end else begin
            rev_cnt_q <= rev_cnt_d;
            nudge_q   <= (rev_cnt_d >= REV_MAX);
        end
    end

    assign nudge_act = nudge_q;
    assign nudge     = nudge_q;
`else
    assign nudge_act = 1'b0;
    assign nudge     = 1'b0;
`endif

    assign hold_req = open_btn | (obstruct & ~nudge_act);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rev_inc = 1'b0;
        rev_clr = 1'b0;
        case (state_q)
            ST_CLOSED: begin
                if ((arrive | open_btn) & ~car_moving) begin
                    state_d = ST_OPENING;
                    timer_d = '0;
                end
            end
            ST_OPENING: begin
                if (timer_q == MOVE_LAST) begin
                    state_d = ST_OPEN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_OPEN: begin
                if (hold_req) begin
                    timer_d = '0;
                end else if (close_btn || (timer_q == HOLD_LAST)) begin
                    state_d = ST_CLOSING;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_CLOSING: begin
                // Reversal takes priority over completing the close; the
                // reopen time mirrors the closing time already spent.
                if (hold_req) begin
                    state_d = ST_OPENING;
                    timer_d = MOVE_LAST - timer_q;
                    rev_inc = 1'b1;
                end else if (timer_q == MOVE_LAST) begin
                    state_d = ST_CLOSED;
                    timer_d = '0;
                    rev_clr = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_CLOSED;
                timer_d = '0;
            end
        endcase
    end

    // Door/motor outputs are registered from the next state so they change
    // on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_CLOSED;
            timer_q       <= '0;
            door_open_q   <= 1'b0;
            door_closed_q <= 1'b1;
            motor_open_q  <= 1'b0;
            motor_close_q <= 1'b0;
            music_en_q    <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            door_open_q   <= (state_d != ST_CLOSED);
            door_closed_q <= (state_d == ST_CLOSED);
            motor_open_q  <= (state_d == ST_OPENING);
            motor_close_q <= (state_d == ST_CLOSING);
            music_en_q    <= car_moving & (state_q == ST_CLOSED) & ~fault_q;
            fault_q       <= fault_q | (car_moving & (state_q != ST_CLOSED));
        end
    end

    assign door_open   = door_open_q;
    assign door_closed = door_closed_q;
    assign motor_open  = motor_open_q;
    assign motor_close = motor_close_q;
    assign music_en    = music_en_q;
    assign fault       = fault_q;

endmodule

// File: doc/lift_door_ctrl.md
Name: lift_door_ctrl

Overview:
Door controller FSM for the lift car. It sequences door opening, dwell, closing and obstruction reversal, and drives the door motor enables. It produces the door_open and music_en status levels consumed by the downstream seven-segment status display. It also provides a door-closed interlock to the motion controller and flags unsafe motion.

Parameters:
MOVE_CYCLES, 100000000, door travel time in clk cycles (1 s at 100 MHz); legal range is 2 or more.
HOLD_CYCLES, 300000000, dwell time with the door fully open, in clk cycles; legal range is 2 or more.
CNT_W, 32, width of the shared timer; must hold max(MOVE_CYCLES, HOLD_CYCLES).
NUDGE_LIMIT, 3, number of obstruction reversals per stop before nudge mode; used only with the optional feature.

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  reset
arrive  in  1  one-cycle pulse: car has stopped at a floor and the door should open
open_btn  in  1  door-open button, level
close_btn  in  1  door-close button, one-cycle pulse
obstruct  in  1  light-curtain obstruction, level, 1 = blocked
car_moving  in  1  level from the motion controller
door_open  out  1  1 whenever the door is not fully closed
door_closed  out  1  1 only in the CLOSED state; this is the motion interlock
motor_open  out  1  opening motor enable
motor_close  out  1  closing motor enable
music_en  out  1  in-car music enable
fault  out  1  sticky safety fault
nudge  out  1  nudge-mode indicator

Behaviour:
- One clock, clk. Reset is synchronous and active-low: rst_n sampled low at a rising clk edge resets the block. Reset has priority over all other inputs and aborts any operation in progress.
- Reset values: state=CLOSED, timer=0, door_open=0, door_closed=1, motor_open=0, motor_close=0, music_en=0, fault=0, nudge=0, reversal count=0.
- The FSM is Moore with all outputs registered. door_open, door_closed, motor_open and motor_close decode from the state register, so they change on the same edge as the state.
- States: CLOSED, OPENING, OPEN, CLOSING. Entering any state loads timer=0 unless stated otherwise.
- CLOSED:
  - (arrive | open_btn) & !car_moving -> OPENING on the next edge.
  - Requests are ignored while car_moving=1.
- OPENING: motor_open=1. The timer increments each cycle. At timer==MOVE_CYCLES-1 -> OPEN. Inputs are ignored in this state.
- OPEN: both motors are 0. The timer counts the dwell.
  - open_btn | obstruct: timer reloads 0 every cycle it is asserted.
  - Otherwise, close_btn -> CLOSING immediately. close_btn is ignored while open_btn or obstruct is high.
  - Otherwise, timer==HOLD_CYCLES-1 -> CLOSING.
- CLOSING: motor_close=1.
  - open_btn | obstruct -> OPENING, with the timer loaded to MOVE_CYCLES-1-timer. Reopen time therefore equals the closing time already elapsed. Reversal counter increments (saturating).
  - Otherwise, at timer==MOVE_CYCLES-1 -> CLOSED. Reversal counter clears.
- Simultaneous events:
  - open_btn on the cycle CLOSING would complete: the reversal wins.
  - arrive together with car_moving: ignored.
- music_en(t+1) = car_moving(t) & (state(t)==CLOSED) & !fault(t).
- fault is set on any cycle where car_moving=1 and state!=CLOSED. It stays set until reset. While fault=1 the FSM forces state OPENING/OPEN behaviour unchanged but music_en=0.
- motor_open and motor_close are never both 1.

Optional Feature:
LIFT_DOOR_NUDGE_EN.
- Defined: once the reversal count reaches NUDGE_LIMIT within one stop, the following apply until CLOSED is reached:
  - nudge=1.
  - obstruct no longer reverses CLOSING; open_btn still does.
  - obstruct no longer restarts the OPEN dwell.
- Undefined: the reversal counter is absent and nudge is tied 0.

Test Plan (MOVE_CYCLES=10, HOLD_CYCLES=20):
1. Reset: rst_n=0 for 2 edges mid-OPENING -> next edge state CLOSED, door_closed=1, all other outputs 0.
2. arrive pulse at edge 0 -> motor_open=1 for edges 1-10; OPEN edges 11-30; motor_close=1 edges 31-40; door_closed=1 at edge 41.
3. obstruct pulse in CLOSING at timer=3 -> OPENING with timer=6; OPEN 4 edges later; reversal count=1.
4. close_btn in OPEN at timer=5 -> CLOSING next edge. Repeat with obstruct=1 -> close_btn ignored and timer held at 0.
5. car_moving=1 while CLOSED -> music_en=1 one edge later. car_moving=1 while OPEN -> fault=1 sticky, music_en=0 until reset.
6. With LIFT_DOOR_NUDGE_EN: 3 obstruct reversals, then obstruct held during the 4th CLOSING -> nudge=1, door closes, nudge=0 at CLOSED. Without the macro: the 4th obstruct reverses and nudge stays 0.
